// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, constants, FSM states and helpers for the FP subtractor.
// ROUND_NEAREST_EN widens the mantissa path by guard/round/sticky bits.
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam int EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0] FP_POS_ZERO = '0;
  localparam int MW = FRAC_W + 1;
`ifdef ROUND_NEAREST_EN
  localparam int GRS = 3;
`else
  localparam int GRS = 0;
`endif
  localparam int XW = MW + GRS;

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADDSUB, NORM, ROUND, DONE
  } fsmState_e;

  function automatic logic [W-1:0] fpInf(input logic sign);
    return {sign, EXP_MAX, {FRAC_W{1'b0}}};
  endfunction
endpackage

// File: rtl/fp_subtractor_if.sv
// fp_subtractor_if: operand/result valid-ready bundle for the FP subtractor.
// master: in_valid, a, b, out_ready out; slave: in_ready, out_valid, result out.
interface fp_subtractor_if;
  import fp_pkg::*;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/fp_align_shifter.sv
// fp_align_shifter: right-shift a 24-bit mantissa by d, zero once d reaches width.
// Ports: mIn mantissa, d shift, mOut aligned (sticky in lsb with ROUND_NEAREST_EN).
module fp_align_shifter
  import fp_pkg::*;
(
  input  logic [MW-1:0]    mIn,
  input  logic [EXP_W-1:0] d,
  output logic [XW-1:0]    mOut
);
`ifdef ROUND_NEAREST_EN
  logic [2*XW-1:0] wide;

  always_comb begin
    wide = {mIn, {(2*XW-MW){1'b0}}} >> d;
    // hidden bit is always set, so a full shift-out leaves only sticky
    if (d >= EXP_W'(XW)) mOut = XW'(1);
    else mOut = wide[2*XW-1:XW] | XW'(|wide[XW-1:0]);
  end
`else
  always_comb begin
    if (d >= EXP_W'(MW)) mOut = '0;
    else mOut = mIn >> d;
  end
`endif
endmodule

// File: rtl/fp_subtractor.sv
// fp_subtractor: multi-cycle single-precision A-B, one normalise step per cycle.
// Ports: clk, rst_n, bus (slave: a, b, in_valid/ready, result, out_valid/ready); ROUND_NEAREST_EN.
module fp_subtractor
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fp_subtractor_if.slave bus
);
  fsmState_e        state;
  logic             aSign, bSign, sign, same, outValid;
  logic [EXP_W-1:0] aExp, bExp, exp;
  logic [FRAC_W-1:0] aFrac, bFrac;
  logic [XW-1:0]    mX, mY;
  logic [W-1:0]     res;

  logic             accept, take, aZero, bZero, aGe;
  logic [EXP_W-1:0] xExp, d, expInc;
  logic [FRAC_W-1:0] xFrac, yFrac;
  logic [XW-1:0]    yAligned, diff;
  logic [XW:0]      sum;

  assign accept = bus.in_valid && (state == IDLE);
  assign take = outValid && bus.out_ready;
  assign aZero = bus.a[W-2:FRAC_W] == '0;
  assign bZero = bus.b[W-2:FRAC_W] == '0;
  assign bus.in_ready = (state == IDLE);
  assign bus.out_valid = outValid;
  assign bus.result = res;

  always_comb begin
    aGe = {aExp, aFrac} >= {bExp, bFrac};
    xExp = aGe ? aExp : bExp;
    xFrac = aGe ? aFrac : bFrac;
    yFrac = aGe ? bFrac : aFrac;
    d = aGe ? aExp - bExp : bExp - aExp;
    sum = {1'b0, mX} + {1'b0, mY};
    diff = mX - mY;
    expInc = exp + EXP_W'(1);
  end

  fp_align_shifter uAlign (
    .mIn  ({1'b1, yFrac}),
    .d    (d),
    .mOut (yAligned)
  );

`ifdef ROUND_NEAREST_EN
  logic          up;
  logic [MW:0]   rSum;

  always_comb begin
    up = mX[2] & (mX[1] | mX[0] | mX[GRS]);
    rSum = {1'b0, mX[XW-1:GRS]} + (MW+1)'(up);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      outValid <= 1'b0;
      res <= FP_POS_ZERO;
      aSign <= 1'b0;
      bSign <= 1'b0;
      sign <= 1'b0;
      same <= 1'b0;
      aExp <= '0;
      bExp <= '0;
      exp <= '0;
      aFrac <= '0;
      bFrac <= '0;
      mX <= '0;
      mY <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          aSign <= bus.a[W-1];
          aExp <= bus.a[W-2:FRAC_W];
          aFrac <= bus.a[FRAC_W-1:0];
          // subtract = add with the subtrahend's sign flipped
          bSign <= ~bus.b[W-1];
          bExp <= bus.b[W-2:FRAC_W];
          bFrac <= bus.b[FRAC_W-1:0];
          if (aZero && bZero) begin
            res <= FP_POS_ZERO;
            outValid <= 1'b1;
            state <= DONE;
          end else if (aZero) begin
            res <= {~bus.b[W-1], bus.b[W-2:0]};
            outValid <= 1'b1;
            state <= DONE;
          end else if (bZero) begin
            res <= bus.a;
            outValid <= 1'b1;
            state <= DONE;
          end else begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sign <= aGe ? aSign : bSign;
          same <= aSign == bSign;
          exp <= xExp;
          mX <= XW'({1'b1, xFrac}) << GRS;
          mY <= yAligned;
          state <= ADDSUB;
        end
        ADDSUB: begin
          if (same) begin
            if (sum[XW]) begin
              exp <= expInc;
`ifdef ROUND_NEAREST_EN
              mX <= sum[XW:1] | XW'(sum[0]);
`else
              mX <= sum[XW:1];
`endif
              if (expInc == EXP_MAX) begin
                res <= fpInf(sign);
                outValid <= 1'b1;
                state <= DONE;
              end else begin
                state <= NORM;
              end
            end else begin
              mX <= sum[XW-1:0];
              state <= NORM;
            end
          end else if (diff == '0) begin
            res <= FP_POS_ZERO;
            outValid <= 1'b1;
            state <= DONE;
          end else begin
            mX <= diff;
            state <= NORM;
          end
        end
        NORM: begin
          if (mX[XW-1]) begin
`ifdef ROUND_NEAREST_EN
            state <= ROUND;
`else
            res <= {sign, exp, mX[XW-2:GRS]};
            outValid <= 1'b1;
            state <= DONE;
`endif
          end else if (exp == EXP_W'(1)) begin
            res <= FP_POS_ZERO;
            outValid <= 1'b1;
            state <= DONE;
          end else begin
            mX <= mX << 1;
            exp <= exp - EXP_W'(1);
          end
        end
`ifdef ROUND_NEAREST_EN
        ROUND: begin
          if (rSum[MW]) begin
            if (expInc == EXP_MAX) res <= fpInf(sign);
            else res <= {sign, expInc, rSum[FRAC_W:1]};
          end else begin
            res <= {sign, exp, rSum[FRAC_W-1:0]};
          end
          outValid <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: if (take) begin
          outValid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_subtractor.sv
// tb_fp_subtractor: directed and random A-B vectors against an arithmetic model.
// Checks results, accept-to-valid latency, backpressure and async reset abort.
`timescale 1ns/1ps
module tb_fp_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nVec = 0;
  int nMis = 0;

  fp_subtractor_if bus();

  fp_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    nVec++;
    assert (got === want) else begin
      nMis++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // exact integer arithmetic on aligned significands, then normalise
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    logic sa, sb, sx;
    int ea, eb, ex, ey, d, k;
    longint mx, my, m;
    sa = a[31];
    sb = ~b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r = 32'h0;
    lat = 1;
    if (ea == 0 && eb == 0) return;
    if (ea == 0) begin
      r = {~b[31], b[30:0]};
      return;
    end
    if (eb == 0) begin
      r = a;
      return;
    end
    if (a[30:0] >= b[30:0]) begin
      sx = sa; ex = ea; ey = eb;
      mx = longint'({1'b1, a[22:0]});
      my = longint'({1'b1, b[22:0]});
    end else begin
      sx = sb; ex = eb; ey = ea;
      mx = longint'({1'b1, b[22:0]});
      my = longint'({1'b1, a[22:0]});
    end
    d = ex - ey;
    my = (d >= 24) ? 0 : (my >> d);
    lat = 3;
    if (sa == sb) begin
      m = mx + my;
      if (m >= (longint'(1) << 24)) begin
        m = m >> 1;
        ex++;
        if (ex == 255) begin
          r = {sx, 8'hFF, 23'h0};
          return;
        end
      end
    end else begin
      m = mx - my;
      if (m == 0) return;
    end
    k = 0;
    while (m < (longint'(1) << 23)) begin
      m = m << 1;
      k++;
    end
    if (k > ex - 1) begin
      r = 32'h0;
      lat = 4 + ex - 1;
    end else begin
      r = {sx, 8'(ex - k), m[22:0]};
      lat = 4 + k;
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       output int n);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic takeOut(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " idle"}, {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] want;
    int lat, n;
    model(a, b, want, lat);
    issue(a, b, n);
    check({tag, " lat"}, 32'(n), 32'(lat));
    check({tag, " res"}, bus.result, want);
    takeOut(tag);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check("reset res", bus.result, 32'h0);
    check("reset flags", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("3-1", 32'h40400000, 32'h3F800000);
    runOp("1-(-1)", 32'h3F800000, 32'hBF800000);
    runOp("ulp", 32'h3F800001, 32'h3F800000);
    runOp("equal", 32'h41200000, 32'h41200000);
    runOp("0-5", 32'h00000000, 32'h40A00000);
    runOp("1-3", 32'h3F800000, 32'h40400000);
    runOp("bzero", 32'h40490FDB, 32'h00123456);
    runOp("zz", 32'h80000001, 32'h00000005);
    runOp("inf", 32'h7F7FFFFF, 32'hFF7FFFFF);
    runOp("uflow", 32'h00800001, 32'h00800000);
    runOp("far", 32'h4B000000, 32'h3F000000);

    issue(32'h40400000, 32'h3F800000, n);
    check("bp lat", 32'(n), 32'd4);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.a = 32'h40A00000;
        bus.b = 32'h00000000;
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      check("bp res", bus.result, 32'h40000000);
      check("bp flags", {30'b0, bus.in_ready, bus.out_valid}, 32'h1);
    end
    bus.in_valid = 1'b0;
    takeOut("bp");
    check("bp kept", bus.result, 32'h40000000);

    @(negedge clk);
    bus.a = 32'h3F800001;
    bus.b = 32'h3F800000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort res", bus.result, 32'h0);
    check("abort flags", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("post", 32'h40400000, 32'h3F800000);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      int ea, eb, sel;
      sel = int'($urandom_range(0, 9));
      ea = int'($urandom_range(1, 254));
      if (sel < 5) eb = ea + int'($urandom_range(0, 4)) - 2;
      else eb = int'($urandom_range(1, 254));
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      ra = {1'($urandom), 8'(ea), 23'($urandom)};
      rb = {1'($urandom), 8'(eb), 23'($urandom)};
      if (sel < 3) rb[22:0] = ra[22:0] ^ 23'($urandom_range(0, 255));
      if (sel == 8) ra[30:23] = 8'h0;
      if (sel == 9) rb[30:23] = 8'h0;
      runOp("rand", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
